tap_controller: RTL

IEEE 1149.1 TAP state machine that sits directly upstream of the JTAG instruction register and the data registers. It decodes TMS on TCK and generates the IR-side controls ShiftIR, ClockIR, UpdateIR and TestReset, plus the matching DR-side controls and the TDO path select/enable. The IR block's ShiftIR/ClockIR/UpdateIR/Reset inputs connect directly to this block's ShiftIR/ClockIR/UpdateIR/TestReset outputs.

---
 rtl/tap_controller.sv | 114 +++++++++++
 1 files changed

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: TMS-driven state machine plus the IR/DR shift,
// clock and update controls and the TDO path select/enable.
`timescale 1ns/1ps
module tap_controller (
  input  logic       TCK,
  input  logic       Reset,
  input  logic       TMS,
  output logic [3:0] State,
  output logic       TestReset,
  output logic       ShiftIR,
  output logic       ClockIR,
  output logic       UpdateIR,
  output logic       ShiftDR,
  output logic       ClockDR,
  output logic       UpdateDR,
  output logic       Select,
  output logic       Enable
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    EX2DR = 4'h0, EX1DR = 4'h1, SHDR  = 4'h2, PAUDR = 4'h3,
    SELIR = 4'h4, UPDDR = 4'h5, CAPDR = 4'h6, SELDR = 4'h7,
    EX2IR = 4'h8, EX1IR = 4'h9, SHIR  = 4'hA, PAUIR = 4'hB,
    RTI   = 4'hC, UPDIR = 4'hD, CAPIR = 4'hE, TLR   = 4'hF
  } tap_state_e;

  tap_state_e state_q;
  tap_state_e state_d;

  logic test_reset_q;
  logic shift_ir_q;
  logic shift_dr_q;
  logic enable_q;
  logic select_q;
  logic clk_ir_en_q;
  logic clk_dr_en_q;
  logic upd_ir_en_q;
  logic upd_dr_en_q;

  // State register: TRST forces Test-Logic-Reset immediately.
  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:   state_d = TMS ? TLR   : RTI;
      RTI:   state_d = TMS ? SELDR : RTI;
      SELDR: state_d = TMS ? SELIR : CAPDR;
      SELIR: state_d = TMS ? TLR   : CAPIR;
      CAPDR: state_d = TMS ? EX1DR : SHDR;
      SHDR:  state_d = TMS ? EX1DR : SHDR;
      EX1DR: state_d = TMS ? UPDDR : PAUDR;
      PAUDR: state_d = TMS ? EX2DR : PAUDR;
      EX2DR: state_d = TMS ? UPDDR : SHDR;
      UPDDR: state_d = TMS ? SELDR : RTI;
      CAPIR: state_d = TMS ? EX1IR : SHIR;
      SHIR:  state_d = TMS ? EX1IR : SHIR;
      EX1IR: state_d = TMS ? UPDIR : PAUIR;
      PAUIR: state_d = TMS ? EX2IR : PAUIR;
      EX2IR: state_d = TMS ? UPDIR : SHIR;
      UPDIR: state_d = TMS ? SELDR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Falling-edge controls; gating terms are settled here so the TCK-combined
  // outputs below cannot glitch.
  always_ff @(negedge TCK or posedge Reset) begin
    if (Reset) begin
      test_reset_q <= 1'b1;
      shift_ir_q   <= 1'b0;
      shift_dr_q   <= 1'b0;
      enable_q     <= 1'b0;
      select_q     <= 1'b1;
      clk_ir_en_q  <= 1'b0;
      clk_dr_en_q  <= 1'b0;
      upd_ir_en_q  <= 1'b0;
      upd_dr_en_q  <= 1'b0;
    end else begin
      test_reset_q <= (state_q == TLR);
      shift_ir_q   <= (state_q == SHIR);
      shift_dr_q   <= (state_q == SHDR);
      enable_q     <= (state_q == SHIR) || (state_q == SHDR);
      select_q     <= state_q[STATE_W-1];
      clk_ir_en_q  <= (state_q == CAPIR) || (state_q == SHIR);
      clk_dr_en_q  <= (state_q == CAPDR) || (state_q == SHDR);
      upd_ir_en_q  <= (state_q == UPDIR);
      upd_dr_en_q  <= (state_q == UPDDR);
    end
  end

  assign State     = state_q;
  assign TestReset = test_reset_q;
  assign ShiftIR   = shift_ir_q;
  assign ShiftDR   = shift_dr_q;
  assign Enable    = enable_q;
  assign Select    = select_q;

  // Capture/shift clocks rise with the TCK edge that leaves Capture/Shift.
  assign ClockIR  = TCK | ~clk_ir_en_q;
  assign ClockDR  = TCK | ~clk_dr_en_q;
  // Update strobes occupy the low phase of TCK in the Update states.
  assign UpdateIR = ~TCK & upd_ir_en_q;
  assign UpdateDR = ~TCK & upd_dr_en_q;

endmodule
